wb_queue: RTL and testbench
===========================

WB_QUEUE -- requirements
Module: wb_queue

Interface
REQ-001 SHALL have parameter: width, 32, data width of register write values.
REQ-002 SHALL have parameter: depth, 4, number of queue entries; power of two, at least 2.
REQ-003 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port: in_valid  input  1  producer offers a writeback result.
REQ-006 SHALL have port: in_ready  output  1  queue can accept this cycle.
REQ-007 SHALL have port: in_addr  input  5  destination register.
REQ-008 SHALL have port: in_data  input  width  result value.
REQ-009 SHALL have port: hold  input  1  register file write port is unavailable this cycle.
REQ-010 SHALL have port: rf_en  output  1  write enable to register file.
REQ-011 SHALL have port: write_addr  output  5  register file write address.
REQ-012 SHALL have port: write_data  output  width  register file write data.
REQ-013 SHALL have port: count  output  $clog2(depth)+1  number of queued entries.
REQ-014 SHALL have port: read_addr_a, read_addr_b  input  5  register file read addresses for the bypass lookup.
REQ-015 SHALL have port: byp_hit_a, byp_hit_b  output  1  the queue holds a pending write to the matching read address.
REQ-016 SHALL have port: byp_data_a, byp_data_b  output  width  pending value for the matching read address.

Function
REQ-017 SHALL accept an entry at a rising edge when in_valid and in_ready are both high.
REQ-018 SHALL drive in_ready high exactly when count < depth; there is no same-cycle pass-through when full.
REQ-019 SHALL complete the handshake for in_addr == 0 but discard the entry, with no change to count.
REQ-020 SHALL present the oldest entry combinationally on write_addr/write_data, with rf_en = (count != 0) and !hold and !rst.
REQ-021 SHALL pop the head at a rising edge when rf_en is high.
REQ-022 SHALL drive write_addr and write_data to 0 when the queue is empty.
REQ-023 SHALL have a minimum latency of one cycle: an entry accepted at edge N produces rf_en in the following cycle, and the register file write occurs at edge N+1.
REQ-024 SHALL, on simultaneous push and pop, leave count unchanged and preserve FIFO order.
REQ-025 SHALL wrap the read and write pointers modulo depth, with no loss of or duplicated entries.
REQ-026 SHALL, while hold is high, keep all entries and continue accepting until full.
REQ-027 SHALL give a bypass hit on a port when any queued entry has an address equal to that read address and the read address is nonzero.
REQ-028 SHALL drive byp_data from the newest matching entry.
REQ-029 SHALL exclude the entry offered on in_* in the same cycle from the bypass lookup.
REQ-030 SHALL include the head entry being written this cycle in the bypass lookup.
REQ-031 SHALL drive byp_data to 0 when there is no hit.

Reset
REQ-032 SHALL, while rst is high at a rising edge, clear count and both pointers and discard all entries.
REQ-033 SHALL hold rf_en at 0 throughout any cycle in which rst is high.
REQ-034 SHALL drive in_ready low while rst is high, so that no entry is accepted in the reset cycle.
REQ-035 SHALL, after reset release, have count = 0, rf_en = 0, write_addr/write_data = 0, in_ready = 1, and byp_hit_a/b = 0.
REQ-036 SHALL, on reset mid-operation, drop pending entries with no register file write issued for them.

Configuration
REQ-037 SHALL, with macro WB_BYPASS_EN defined, implement the bypass lookup of REQ-027 to REQ-031.
REQ-038 SHALL, without WB_BYPASS_EN, keep all bypass ports with byp_hit_a/b tied to 0, byp_data_a/b tied to 0, and read_addr_a/b ignored; all other behaviour SHALL be identical.

Verification
REQ-039 SHALL cover: push (addr 5, data 0xDEADBEEF) with hold = 0 -> next cycle rf_en = 1, write_addr = 5, write_data = 0xDEADBEEF; following cycle count = 0 and rf_en = 0.
REQ-040 SHALL cover: hold = 1 and 5 pushes (addr 1..5) -> first 4 accepted, count = 4, in_ready = 0 on the 5th; after hold = 0, addrs 1, 2, 3, 4 written in order on 4 consecutive cycles.
REQ-041 SHALL cover: push addr 0 data 0x1234 -> in_ready = 1 and handshake completes, count stays 0, rf_en never asserts.
REQ-042 SHALL cover: hold = 1, push (7, 0xA), then (7, 0xB), read_addr_a = 7 -> byp_hit_a = 1, byp_data_a = 0xB; read_addr_b = 0 -> byp_hit_b = 0. Without WB_BYPASS_EN, both hits read 0.
REQ-043 SHALL cover: 3 entries queued, rst = 1 for 1 cycle -> rf_en = 0 during the reset cycle, count = 0 and in_ready = 1 afterwards, and no queued write appears.
REQ-044 SHALL cover: 10 cycles of continuous push and pop with random data and hold = 0 -> count stays 1 after the first push, and the written sequence equals the pushed sequence across pointer wrap.

Source files
------------

// File: rtl/wb_queue_if.sv
// Writeback queue bus: producer handshake, register file write port,
// occupancy and the two bypass lookup ports. clk/rst stay outside.
//
// Handshake: an entry moves from producer to queue at a rising edge where
// in_valid and in_ready are both high. in_valid/in_addr/in_data must stay
// stable while in_valid is high and in_ready is low. The register file side
// has no ready: it refuses a write by raising hold, and the head is consumed
// at every rising edge where rf_en is high.
interface wb_queue_if #(
  parameter int width = 32,
  parameter int depth = 4
);
  logic                     in_valid;
  logic                     in_ready;
  logic [4:0]               in_addr;
  logic [width-1:0]         in_data;
  logic                     hold;
  logic                     rf_en;
  logic [4:0]               write_addr;
  logic [width-1:0]         write_data;
  logic [$clog2(depth):0]   count;
  logic [4:0]               read_addr_a;
  logic [4:0]               read_addr_b;
  logic                     byp_hit_a;
  logic                     byp_hit_b;
  logic [width-1:0]         byp_data_a;
  logic [width-1:0]         byp_data_b;

  // Producer / register-file / test side.
  modport master (
    output in_valid, in_addr, in_data, hold, read_addr_a, read_addr_b,
    input  in_ready, rf_en, write_addr, write_data, count,
           byp_hit_a, byp_hit_b, byp_data_a, byp_data_b
  );

  // Queue side.
  modport slave (
    input  in_valid, in_addr, in_data, hold, read_addr_a, read_addr_b,
    output in_ready, rf_en, write_addr, write_data, count,
           byp_hit_a, byp_hit_b, byp_data_a, byp_data_b
  );
endinterface

// File: rtl/wb_queue.sv
// Writeback queue: buffers register file writes while the write port is
// held off, and presents the oldest entry to the register file.
// Optional feature macro: WB_BYPASS_EN enables the bypass lookup that lets
// readers see values still waiting in the queue (newest match wins).
module wb_queue #(
  parameter int width = 32,
  parameter int depth = 4
) (
  input  logic        clk,
  input  logic        rst,
  wb_queue_if.slave   bus
);
  localparam int aw = $clog2(depth);
  localparam logic [aw:0] depth_c = (aw + 1)'(depth);

  logic [4:0]       addr_mem [depth];
  logic [width-1:0] data_mem [depth];
  logic [aw-1:0]    rd_ptr;
  logic [aw-1:0]    wr_ptr;
  logic [aw:0]      cnt;

  logic in_ready;
  logic accept;
  logic push;
  logic pop;

  // Accept only when not full and not in reset; address 0 completes the
  // handshake but is dropped because register 0 is never written.
  assign in_ready = !rst && (cnt < depth_c);
  assign accept   = bus.in_valid && in_ready;
  assign push     = accept && (bus.in_addr != 5'd0);
  assign pop      = (cnt != '0) && !bus.hold && !rst;

  assign bus.in_ready   = in_ready;
  assign bus.rf_en      = pop;
  assign bus.count      = cnt;
  assign bus.write_addr = (cnt != '0) ? addr_mem[rd_ptr] : 5'd0;
  assign bus.write_data = (cnt != '0) ? data_mem[rd_ptr] : '0;

  // Pointer and occupancy update; pointers wrap naturally at depth.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + aw'(1);
      if (pop)  rd_ptr <= rd_ptr + aw'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + (aw + 1)'(1);
        2'b01:   cnt <= cnt - (aw + 1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Entry storage; contents are meaningful only below the occupancy count.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr] <= bus.in_addr;
      data_mem[wr_ptr] <= bus.in_data;
    end
  end

`ifdef WB_BYPASS_EN
  logic [aw-1:0]    idx;
  logic             hit_a;
  logic             hit_b;
  logic [width-1:0] data_a;
  logic [width-1:0] data_b;

  // Scan stored entries oldest to newest so the last match is the newest.
  // The in-flight offer is not stored yet and so never matches; the head is
  // still stored during its write cycle and so does.
  always_comb begin
    idx    = '0;
    hit_a  = 1'b0;
    hit_b  = 1'b0;
    data_a = '0;
    data_b = '0;
    for (int i = 0; i < depth; i++) begin
      idx = rd_ptr + aw'(i);
      if ((aw + 1)'(i) < cnt) begin
        if (bus.read_addr_a != 5'd0 && addr_mem[idx] == bus.read_addr_a) begin
          hit_a  = 1'b1;
          data_a = data_mem[idx];
        end
        if (bus.read_addr_b != 5'd0 && addr_mem[idx] == bus.read_addr_b) begin
          hit_b  = 1'b1;
          data_b = data_mem[idx];
        end
      end
    end
  end

  assign bus.byp_hit_a  = hit_a;
  assign bus.byp_hit_b  = hit_b;
  assign bus.byp_data_a = data_a;
  assign bus.byp_data_b = data_b;
`else
  logic unused_read_addr;
  assign unused_read_addr = ^{bus.read_addr_a, bus.read_addr_b};

  assign bus.byp_hit_a  = 1'b0;
  assign bus.byp_hit_b  = 1'b0;
  assign bus.byp_data_a = '0;
  assign bus.byp_data_b = '0;
`endif
endmodule

// File: tb/tb_wb_queue.sv
// Bench for wb_queue: directed scenarios plus a randomized run, all checked
// against a queue-based reference model of pending register writes.
module tb_wb_queue;
  localparam int W     = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  logic [4:0]   exp_addr_q[$];
  logic [W-1:0] exp_q[$];

  wb_queue_if #(.width(W), .depth(DEPTH)) bus ();

  wb_queue #(.width(W), .depth(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model views
  function automatic logic exp_hit(input logic [4:0] ra);
    exp_hit = 1'b0;
`ifdef WB_BYPASS_EN
    if (ra != 5'd0)
      foreach (exp_addr_q[i]) if (exp_addr_q[i] == ra) exp_hit = 1'b1;
`endif
  endfunction

  function automatic logic [W-1:0] exp_byp(input logic [4:0] ra);
    exp_byp = '0;
`ifdef WB_BYPASS_EN
    if (ra != 5'd0)
      foreach (exp_addr_q[i]) if (exp_addr_q[i] == ra) exp_byp = exp_q[i];
`endif
  endfunction

  function automatic logic [4:0] exp_waddr();
    exp_waddr = (exp_q.size() != 0) ? exp_addr_q[0] : 5'd0;
  endfunction

  function automatic logic [W-1:0] exp_wdata();
    exp_wdata = (exp_q.size() != 0) ? exp_q[0] : '0;
  endfunction

  // Advance the model with the inputs present now, then cross the edge.
  task automatic tick();
    logic do_push;
    logic do_pop;
    if (rst) begin
      exp_addr_q.delete();
      exp_q.delete();
    end else begin
      do_pop  = (exp_q.size() != 0) && !bus.hold;
      do_push = bus.in_valid && (exp_q.size() < DEPTH) && (bus.in_addr != 5'd0);
      if (do_pop) begin
        void'(exp_addr_q.pop_front());
        void'(exp_q.pop_front());
      end
      if (do_push) begin
        exp_addr_q.push_back(bus.in_addr);
        exp_q.push_back(bus.in_data);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_valid    = 1'b0;
    bus.in_addr     = 5'd0;
    bus.in_data     = '0;
    bus.hold        = 1'b0;
    bus.read_addr_a = 5'd0;
    bus.read_addr_b = 5'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    bus.in_valid = 1'b1;
    bus.in_addr  = 5'd9;
    @(negedge clk);
    total++;
    if (bus.in_ready !== 1'b0) begin
      bad++; $display("FAIL reset_in_ready got=%0b want=0", bus.in_ready);
    end
    total++;
    if (bus.rf_en !== 1'b0) begin
      bad++; $display("FAIL reset_rf_en got=%0b want=0", bus.rf_en);
    end
    tick();
    tick();
    rst = 1'b0;
    idle_inputs();
    bus.read_addr_a = 5'd9;
    bus.read_addr_b = 5'd3;
    @(negedge clk);
    total++;
    if (bus.count !== CW'(0) || bus.rf_en !== 1'b0 || bus.in_ready !== 1'b1) begin
      bad++; $display("FAIL post_reset count=%0d rf_en=%0b in_ready=%0b want 0/0/1",
                      bus.count, bus.rf_en, bus.in_ready);
    end
    total++;
    if (bus.write_addr !== 5'd0 || bus.write_data !== '0) begin
      bad++; $display("FAIL post_reset_write addr=%0d data=%h want 0/0",
                      bus.write_addr, bus.write_data);
    end
    total++;
    if (bus.byp_hit_a !== 1'b0 || bus.byp_hit_b !== 1'b0) begin
      bad++; $display("FAIL post_reset_hits a=%0b b=%0b want 0/0", bus.byp_hit_a, bus.byp_hit_b);
    end
    tick();
  endtask

  task automatic test_single_push();
    idle_inputs();
    bus.in_valid = 1'b1;
    bus.in_addr  = 5'd5;
    bus.in_data  = 32'hDEADBEEF;
    @(negedge clk);
    total++;
    if (bus.in_ready !== 1'b1 || bus.rf_en !== 1'b0) begin
      bad++; $display("FAIL single_offer in_ready=%0b rf_en=%0b want 1/0", bus.in_ready, bus.rf_en);
    end
    tick();
    idle_inputs();
    @(negedge clk);
    total++;
    if (bus.rf_en !== 1'b1 || bus.write_addr !== 5'd5 || bus.write_data !== 32'hDEADBEEF) begin
      bad++; $display("FAIL single_write rf_en=%0b addr=%0d data=%h want 1/5/deadbeef",
                      bus.rf_en, bus.write_addr, bus.write_data);
    end
    tick();
    @(negedge clk);
    total++;
    if (bus.count !== CW'(0) || bus.rf_en !== 1'b0) begin
      bad++; $display("FAIL single_drain count=%0d rf_en=%0b want 0/0", bus.count, bus.rf_en);
    end
    tick();
  endtask

  task automatic test_hold_fill();
    idle_inputs();
    bus.hold = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      bus.in_valid = 1'b1;
      bus.in_addr  = 5'(k);
      bus.in_data  = W'(k * 32'h11);
      @(negedge clk);
      total++;
      if (bus.in_ready !== (k <= 4)) begin
        bad++; $display("FAIL hold_in_ready push=%0d got=%0b want=%0b", k, bus.in_ready, k <= 4);
      end
      total++;
      if (bus.rf_en !== 1'b0) begin
        bad++; $display("FAIL hold_rf_en push=%0d got=%0b want=0", k, bus.rf_en);
      end
      tick();
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    total++;
    if (bus.count !== CW'(4) || bus.in_ready !== 1'b0) begin
      bad++; $display("FAIL hold_full count=%0d in_ready=%0b want 4/0", bus.count, bus.in_ready);
    end
    tick();
    bus.hold = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      total++;
      if (bus.rf_en !== 1'b1 || bus.write_addr !== 5'(k) || bus.write_data !== W'(k * 32'h11)) begin
        bad++; $display("FAIL hold_drain step=%0d rf_en=%0b addr=%0d data=%h want 1/%0d/%h",
                        k, bus.rf_en, bus.write_addr, bus.write_data, k, k * 32'h11);
      end
      tick();
    end
    @(negedge clk);
    total++;
    if (bus.count !== CW'(0) || bus.rf_en !== 1'b0) begin
      bad++; $display("FAIL hold_empty count=%0d rf_en=%0b want 0/0", bus.count, bus.rf_en);
    end
    tick();
  endtask

  task automatic test_addr_zero();
    idle_inputs();
    bus.in_valid = 1'b1;
    bus.in_addr  = 5'd0;
    bus.in_data  = 32'h1234;
    @(negedge clk);
    total++;
    if (bus.in_ready !== 1'b1) begin
      bad++; $display("FAIL zero_in_ready got=%0b want=1", bus.in_ready);
    end
    tick();
    idle_inputs();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      total++;
      if (bus.count !== CW'(0) || bus.rf_en !== 1'b0) begin
        bad++; $display("FAIL zero_dropped cyc=%0d count=%0d rf_en=%0b want 0/0",
                        k, bus.count, bus.rf_en);
      end
      tick();
    end
  endtask

  task automatic test_bypass();
    logic [W-1:0] want_data;
    logic         want_hit;
    idle_inputs();
    bus.hold     = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_addr  = 5'd7;
    bus.in_data  = 32'hA;
    tick();
    bus.in_data  = 32'hB;
    tick();
    // Offer a third write to r7; it must not be visible until stored.
    bus.in_data     = 32'hC;
    bus.read_addr_a = 5'd7;
    bus.read_addr_b = 5'd0;
`ifdef WB_BYPASS_EN
    want_hit  = 1'b1;
    want_data = 32'hB;
`else
    want_hit  = 1'b0;
    want_data = '0;
`endif
    @(negedge clk);
    total++;
    if (bus.byp_hit_a !== want_hit || bus.byp_data_a !== want_data) begin
      bad++; $display("FAIL bypass_a hit=%0b data=%h want %0b/%h",
                      bus.byp_hit_a, bus.byp_data_a, want_hit, want_data);
    end
    total++;
    if (bus.byp_hit_b !== 1'b0 || bus.byp_data_b !== '0) begin
      bad++; $display("FAIL bypass_b_zero hit=%0b data=%h want 0/0", bus.byp_hit_b, bus.byp_data_b);
    end
    bus.in_valid = 1'b0;
    bus.hold     = 1'b0;
    // Drain with lookups on the head while it is being written.
    for (int k = 0; k < 4; k++) begin
      bus.read_addr_b = 5'd7;
      @(negedge clk);
      total++;
      if (bus.byp_hit_b !== exp_hit(5'd7) || bus.byp_data_b !== exp_byp(5'd7)) begin
        bad++; $display("FAIL bypass_drain step=%0d hit=%0b data=%h want %0b/%h", k,
                        bus.byp_hit_b, bus.byp_data_b, exp_hit(5'd7), exp_byp(5'd7));
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    bus.hold = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.in_valid = 1'b1;
      bus.in_addr  = 5'(10 + k);
      bus.in_data  = $urandom;
      tick();
    end
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (bus.rf_en !== 1'b0) begin
      bad++; $display("FAIL midreset_rf_en got=%0b want=0", bus.rf_en);
    end
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++;
      if (bus.count !== CW'(0) || bus.in_ready !== 1'b1 || bus.rf_en !== 1'b0) begin
        bad++; $display("FAIL midreset_after cyc=%0d count=%0d in_ready=%0b rf_en=%0b want 0/1/0",
                        k, bus.count, bus.in_ready, bus.rf_en);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    idle_inputs();
    for (int k = 0; k < 10; k++) begin
      bus.in_valid = 1'b1;
      bus.in_addr  = 5'($urandom_range(1, 31));
      bus.in_data  = $urandom;
      @(negedge clk);
      if (k > 0) begin
        total++;
        if (bus.count !== CW'(1)) begin
          bad++; $display("FAIL b2b_count cyc=%0d got=%0d want=1", k, bus.count);
        end
        total++;
        if (bus.rf_en !== 1'b1 || bus.write_addr !== exp_waddr() || bus.write_data !== exp_wdata()) begin
          bad++; $display("FAIL b2b_write cyc=%0d rf_en=%0b addr=%0d data=%h want 1/%0d/%h",
                          k, bus.rf_en, bus.write_addr, bus.write_data, exp_waddr(), exp_wdata());
        end
      end
      tick();
    end
    idle_inputs();
    @(negedge clk);
    total++;
    if (bus.rf_en !== 1'b1 || bus.write_addr !== exp_waddr() || bus.write_data !== exp_wdata()) begin
      bad++; $display("FAIL b2b_last rf_en=%0b addr=%0d data=%h want 1/%0d/%h",
                      bus.rf_en, bus.write_addr, bus.write_data, exp_waddr(), exp_wdata());
    end
    tick();
  endtask

  task automatic test_random();
    for (int k = 0; k < 300; k++) begin
      rst          = ($urandom_range(0, 49) == 0);
      bus.in_valid = $urandom_range(0, 1);
      bus.in_addr  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      bus.in_data  = $urandom;
      bus.hold     = ($urandom_range(0, 2) == 0);
      if (exp_addr_q.size() != 0 && $urandom_range(0, 1) == 1)
        bus.read_addr_a = exp_addr_q[$urandom_range(0, exp_addr_q.size() - 1)];
      else
        bus.read_addr_a = 5'($urandom_range(0, 31));
      bus.read_addr_b = ($urandom_range(0, 1) == 1) ? bus.in_addr : 5'($urandom_range(0, 3));
      @(negedge clk);
      total++;
      if (bus.count !== CW'(exp_q.size()) ||
          bus.in_ready !== (!rst && exp_q.size() < DEPTH)) begin
        bad++; $display("FAIL rand_occupancy cyc=%0d count=%0d in_ready=%0b want %0d/%0b", k,
                        bus.count, bus.in_ready, exp_q.size(), !rst && exp_q.size() < DEPTH);
      end
      total++;
      if (bus.rf_en !== (!rst && !bus.hold && exp_q.size() != 0) ||
          bus.write_addr !== exp_waddr() || bus.write_data !== exp_wdata()) begin
        bad++; $display("FAIL rand_write cyc=%0d rf_en=%0b addr=%0d data=%h want %0b/%0d/%h", k,
                        bus.rf_en, bus.write_addr, bus.write_data,
                        !rst && !bus.hold && exp_q.size() != 0, exp_waddr(), exp_wdata());
      end
      if (!rst) begin
        total++;
        if (bus.byp_hit_a !== exp_hit(bus.read_addr_a) || bus.byp_data_a !== exp_byp(bus.read_addr_a) ||
            bus.byp_hit_b !== exp_hit(bus.read_addr_b) || bus.byp_data_b !== exp_byp(bus.read_addr_b)) begin
          bad++; $display("FAIL rand_bypass cyc=%0d a=%0b/%h b=%0b/%h want %0b/%h %0b/%h", k,
                          bus.byp_hit_a, bus.byp_data_a, bus.byp_hit_b, bus.byp_data_b,
                          exp_hit(bus.read_addr_a), exp_byp(bus.read_addr_a),
                          exp_hit(bus.read_addr_b), exp_byp(bus.read_addr_b));
        end
      end
      tick();
    end
    rst = 1'b0;
    idle_inputs();
  endtask

  // Sequencer and final report
  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    idle_inputs();
    #1;
    test_reset();
    test_single_push();
    test_hold_fill();
    test_addr_zero();
    test_bypass();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
